// File: rtl/cpu_axil_bridge.sv
// Bridges a level-held CPU register request onto an AXI-Lite master port.
// Completion is reported with a one-cycle ack_o/err_o pulse; all outputs are registered.
module cpu_axil_bridge #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic                      req_we_i,
    input  logic                      req_re_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      ack_o,
    output logic                      err_o,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr_o,
    output logic                      m_axi_awvalid_o,
    input  logic                      m_axi_awready_i,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb_o,
    output logic                      m_axi_wvalid_o,
    input  logic                      m_axi_wready_i,
    input  logic                      m_axi_bvalid_i,
    input  logic [1:0]                m_axi_bresp_i,
    output logic                      m_axi_bready_o,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr_o,
    output logic                      m_axi_arvalid_o,
    input  logic                      m_axi_arready_i,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata_i,
    input  logic [1:0]                m_axi_rresp_i,
    input  logic                      m_axi_rvalid_i,
    output logic                      m_axi_rready_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    timeout_hit;
    logic                    abort;
    logic                    unused_resp_lsbs;

    // Only the upper response bit distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    assign unused_resp_lsbs = m_axi_bresp_i[0] ^ m_axi_rresp_i[0];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        abort     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_we_i) begin
                    addr_d    = req_addr_i;
                    wdata_d   = req_wdata_i;
                    wstrb_d   = '1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR;
                end else if (req_re_i) begin
                    addr_d    = req_addr_i;
                    arvalid_d = 1'b1;
                    state_d   = RD_ADDR;
                end
            end
            WR: begin
                awvalid_d = awvalid_q & ~m_axi_awready_i;
                wvalid_d  = wvalid_q & ~m_axi_wready_i;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid_i) begin
                    bready_d = 1'b0;
                    err_d    = m_axi_bresp_i[1];
                    ack_d    = 1'b1;
                    state_d  = DONE;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid_i) begin
                    rdata_d  = m_axi_rdata_i;
                    err_d    = m_axi_rresp_i[1];
                    rready_d = 1'b0;
                    ack_d    = 1'b1;
                    state_d  = DONE;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout abandons the transfer outright; any late slave response finds us idle.
        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            rdata_d   = '0;
            ack_d     = 1'b1;
            err_d     = 1'b1;
            state_d   = DONE;
        end

        if ((state_d != state_q) || (state_q == IDLE) || (state_q == DONE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign rdata_o         = rdata_q;
    assign ack_o           = ack_q;
    assign err_o           = err_q;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_awvalid_o = awvalid_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign m_axi_wvalid_o  = wvalid_q;
    assign m_axi_bready_o  = bready_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arvalid_o = arvalid_q;
    assign m_axi_rready_o  = rready_q;

endmodule

// File: tb/tb_cpu_axil_bridge.sv
// Directed bench for cpu_axil_bridge with a hand-driven AXI-Lite slave and TIMEOUT_CYCLES=8.
`timescale 1ns/1ps
module tb_cpu_axil_bridge;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_we_i;
    logic        req_re_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        err_o;
    logic [4:0]  m_axi_awaddr_o;
    logic        m_axi_awvalid_o;
    logic        m_axi_awready_i;
    logic [31:0] m_axi_wdata_o;
    logic [3:0]  m_axi_wstrb_o;
    logic        m_axi_wvalid_o;
    logic        m_axi_wready_i;
    logic        m_axi_bvalid_i;
    logic [1:0]  m_axi_bresp_i;
    logic        m_axi_bready_o;
    logic [4:0]  m_axi_araddr_o;
    logic        m_axi_arvalid_o;
    logic        m_axi_arready_i;
    logic [31:0] m_axi_rdata_i;
    logic [1:0]  m_axi_rresp_i;
    logic        m_axi_rvalid_i;
    logic        m_axi_rready_o;

    int total = 0;
    int bad   = 0;
    int aw_hs = 0;
    int w_hs  = 0;
    int ar_hs = 0;
    int acks  = 0;
    int aw0, w0, ar0, ack0, n;

    cpu_axil_bridge #(
        .ADDR_WIDTH     (5),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .req_we_i        (req_we_i),
        .req_re_i        (req_re_i),
        .rdata_o         (rdata_o),
        .ack_o           (ack_o),
        .err_o           (err_o),
        .m_axi_awaddr_o  (m_axi_awaddr_o),
        .m_axi_awvalid_o (m_axi_awvalid_o),
        .m_axi_awready_i (m_axi_awready_i),
        .m_axi_wdata_o   (m_axi_wdata_o),
        .m_axi_wstrb_o   (m_axi_wstrb_o),
        .m_axi_wvalid_o  (m_axi_wvalid_o),
        .m_axi_wready_i  (m_axi_wready_i),
        .m_axi_bvalid_i  (m_axi_bvalid_i),
        .m_axi_bresp_i   (m_axi_bresp_i),
        .m_axi_bready_o  (m_axi_bready_o),
        .m_axi_araddr_o  (m_axi_araddr_o),
        .m_axi_arvalid_o (m_axi_arvalid_o),
        .m_axi_arready_i (m_axi_arready_i),
        .m_axi_rdata_i   (m_axi_rdata_i),
        .m_axi_rresp_i   (m_axi_rresp_i),
        .m_axi_rvalid_i  (m_axi_rvalid_i),
        .m_axi_rready_o  (m_axi_rready_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (m_axi_awvalid_o && m_axi_awready_i) aw_hs <= aw_hs + 1;
        if (m_axi_wvalid_o && m_axi_wready_i)   w_hs  <= w_hs + 1;
        if (m_axi_arvalid_o && m_axi_arready_i) ar_hs <= ar_hs + 1;
        if (ack_o)                              acks  <= acks + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic slave_idle;
        m_axi_awready_i = 1'b0;
        m_axi_wready_i  = 1'b0;
        m_axi_bvalid_i  = 1'b0;
        m_axi_bresp_i   = 2'b00;
        m_axi_arready_i = 1'b0;
        m_axi_rvalid_i  = 1'b0;
        m_axi_rresp_i   = 2'b00;
        m_axi_rdata_i   = 32'h0;
    endtask

    task automatic wait_ack(input int max_cycles, output int cycles);
        cycles = 0;
        while (!ack_o && cycles < max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i     = 1'b1;
        req_addr_i  = 5'h0;
        req_wdata_i = 32'h0;
        req_we_i    = 1'b0;
        req_re_i    = 1'b0;
        slave_idle();
        repeat (2) tick();
        chk("rst_ctl", 32'({ack_o, err_o, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o,
                            m_axi_arvalid_o, m_axi_rready_o}), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_wstrb", 32'(m_axi_wstrb_o), 32'h0);
        chk("rst_awaddr", 32'(m_axi_awaddr_o), 32'h0);
        reset_i = 1'b0;
        tick();

        // Write, all ready: AW/W at N+1, B at N+2, ack sampled at N+3
        aw0 = aw_hs; w0 = w_hs; ack0 = acks;
        req_we_i = 1'b1; req_addr_i = 5'h04; req_wdata_i = 32'hA5A5_0001;
        m_axi_awready_i = 1'b1; m_axi_wready_i = 1'b1;
        tick();
        chk("t1_awvalid", 32'(m_axi_awvalid_o), 32'h1);
        chk("t1_wvalid", 32'(m_axi_wvalid_o), 32'h1);
        chk("t1_awaddr", 32'(m_axi_awaddr_o), 32'h04);
        chk("t1_wstrb", 32'(m_axi_wstrb_o), 32'hF);
        chk("t1_wdata", m_axi_wdata_o, 32'hA5A5_0001);
        m_axi_bvalid_i = 1'b1;
        tick();
        chk("t1_valids_drop", 32'({m_axi_awvalid_o, m_axi_wvalid_o}), 32'h0);
        chk("t1_bready", 32'(m_axi_bready_o), 32'h1);
        tick();
        chk("t1_ack", 32'(ack_o), 32'h1);
        chk("t1_err", 32'(err_o), 32'h0);
        chk("t1_bready_drop", 32'(m_axi_bready_o), 32'h0);
        req_we_i = 1'b0;
        slave_idle();
        tick();
        chk("t1_ack_pulse", 32'(ack_o), 32'h0);
        chk("t1_aw_beats", 32'(aw_hs - aw0), 32'h1);
        chk("t1_w_beats", 32'(w_hs - w0), 32'h1);

        // W accepted at N+1, AW only at N+4
        aw0 = aw_hs; w0 = w_hs; ack0 = acks;
        req_we_i = 1'b1; req_addr_i = 5'h08; req_wdata_i = 32'h0BAD_F00D;
        m_axi_wready_i = 1'b1;
        tick();
        tick();
        chk("t2_wvalid_drop", 32'(m_axi_wvalid_o), 32'h0);
        chk("t2_awvalid_held", 32'(m_axi_awvalid_o), 32'h1);
        tick();
        tick();
        chk("t2_awvalid_held2", 32'(m_axi_awvalid_o), 32'h1);
        chk("t2_bready_low", 32'(m_axi_bready_o), 32'h0);
        m_axi_awready_i = 1'b1;
        tick();
        chk("t2_awvalid_drop", 32'(m_axi_awvalid_o), 32'h0);
        chk("t2_bready", 32'(m_axi_bready_o), 32'h1);
        m_axi_awready_i = 1'b0; m_axi_wready_i = 1'b0; m_axi_bvalid_i = 1'b1;
        tick();
        chk("t2_ack", 32'(ack_o), 32'h1);
        chk("t2_err", 32'(err_o), 32'h0);
        req_we_i = 1'b0;
        slave_idle();
        tick();
        tick();
        chk("t2_w_beats", 32'(w_hs - w0), 32'h1);
        chk("t2_aw_beats", 32'(aw_hs - aw0), 32'h1);
        chk("t2_acks", 32'(acks - ack0), 32'h1);

        // Read 0x10, rvalid delayed
        req_re_i = 1'b1; req_addr_i = 5'h10; m_axi_arready_i = 1'b1;
        tick();
        chk("t3_arvalid", 32'(m_axi_arvalid_o), 32'h1);
        chk("t3_araddr", 32'(m_axi_araddr_o), 32'h10);
        tick();
        chk("t3_arvalid_drop", 32'(m_axi_arvalid_o), 32'h0);
        chk("t3_rready", 32'(m_axi_rready_o), 32'h1);
        m_axi_arready_i = 1'b0;
        tick();
        tick();
        chk("t3_rready_held", 32'(m_axi_rready_o), 32'h1);
        chk("t3_ack_early", 32'(ack_o), 32'h0);
        m_axi_rvalid_i = 1'b1; m_axi_rdata_i = 32'h1234_5678;
        tick();
        chk("t3_ack", 32'(ack_o), 32'h1);
        chk("t3_rdata", rdata_o, 32'h1234_5678);
        chk("t3_err", 32'(err_o), 32'h0);
        chk("t3_rready_drop", 32'(m_axi_rready_o), 32'h0);
        req_re_i = 1'b0;
        slave_idle();
        m_axi_rdata_i = 32'hFFFF_FFFF;
        tick();
        chk("t3_rdata_hold", rdata_o, 32'h1234_5678);

        // Read with SLVERR: data still captured
        req_re_i = 1'b1; req_addr_i = 5'h0C;
        m_axi_arready_i = 1'b1; m_axi_rvalid_i = 1'b1;
        m_axi_rresp_i = 2'b10; m_axi_rdata_i = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("t4_ack_early", 32'(ack_o), 32'h0);
        tick();
        chk("t4_ack", 32'(ack_o), 32'h1);
        chk("t4_err", 32'(err_o), 32'h1);
        chk("t4_rdata", rdata_o, 32'hDEAD_BEEF);
        req_re_i = 1'b0;
        slave_idle();
        tick();

        // AW never accepted: abort after 8 cycles in WR, late B ignored
        ack0 = acks;
        req_we_i = 1'b1; req_addr_i = 5'h14; req_wdata_i = 32'h1;
        m_axi_wready_i = 1'b1;
        repeat (8) tick();
        chk("t5_awvalid_held", 32'(m_axi_awvalid_o), 32'h1);
        chk("t5_ack_early", 32'(ack_o), 32'h0);
        tick();
        chk("t5_ack", 32'(ack_o), 32'h1);
        chk("t5_err", 32'(err_o), 32'h1);
        chk("t5_valids_drop", 32'({m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o}), 32'h0);
        chk("t5_rdata_zero", rdata_o, 32'h0);
        req_we_i = 1'b0;
        m_axi_wready_i = 1'b0; m_axi_bvalid_i = 1'b1;
        repeat (4) tick();
        chk("t5_single_ack", 32'(acks - ack0), 32'h1);
        chk("t5_bready_low", 32'(m_axi_bready_o), 32'h0);
        slave_idle();
        tick();

        // Reset while waiting in RD_DATA, then a clean read
        req_re_i = 1'b1; req_addr_i = 5'h18; m_axi_arready_i = 1'b1;
        tick();
        tick();
        chk("t6_rready", 32'(m_axi_rready_o), 32'h1);
        m_axi_arready_i = 1'b0; req_re_i = 1'b0; reset_i = 1'b1;
        ack0 = acks;
        tick();
        chk("t6_rst_ctl", 32'({ack_o, err_o, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o,
                               m_axi_arvalid_o, m_axi_rready_o}), 32'h0);
        chk("t6_rst_araddr", 32'(m_axi_araddr_o), 32'h0);
        reset_i = 1'b0;
        tick();
        chk("t6_no_ack", 32'(acks - ack0), 32'h0);
        req_re_i = 1'b1; req_addr_i = 5'h08;
        m_axi_arready_i = 1'b1; m_axi_rvalid_i = 1'b1; m_axi_rdata_i = 32'hCAFE_F00D;
        wait_ack(10, n);
        chk("t6_ack_seen", 32'(ack_o), 32'h1);
        chk("t6_latency", 32'(n), 32'h3);
        chk("t6_rdata", rdata_o, 32'hCAFE_F00D);
        chk("t6_err", 32'(err_o), 32'h0);
        req_re_i = 1'b0;
        slave_idle();
        tick();

        // we and re together: write wins; DECERR response; held request restarts
        ar0 = ar_hs;
        req_we_i = 1'b1; req_re_i = 1'b1; req_addr_i = 5'h1C; req_wdata_i = 32'h5555_AAAA;
        m_axi_awready_i = 1'b1; m_axi_wready_i = 1'b1;
        m_axi_bvalid_i = 1'b1; m_axi_bresp_i = 2'b11;
        tick();
        chk("t7_awvalid", 32'(m_axi_awvalid_o), 32'h1);
        chk("t7_arvalid", 32'(m_axi_arvalid_o), 32'h0);
        wait_ack(10, n);
        chk("t7_latency", 32'(n), 32'h2);
        chk("t7_err", 32'(err_o), 32'h1);
        tick();
        chk("t7_ack_pulse", 32'(ack_o), 32'h0);
        tick();
        chk("t7_rereq_awvalid", 32'(m_axi_awvalid_o), 32'h1);
        req_we_i = 1'b0; req_re_i = 1'b0;
        wait_ack(10, n);
        chk("t7_rereq_ack", 32'(ack_o), 32'h1);
        chk("t7_no_read", 32'(ar_hs - ar0), 32'h0);
        slave_idle();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
